sha256_compress_ctrl: RTL

SHA256_COMPRESS_CTRL -- requirements
Module: sha256_compress_ctrl

---
 rtl/sha256_compress_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/sha256_compress_ctrl.sv
// SHA-256 compression controller: loads 16-word blocks, runs 64 rounds one per cycle,
// accumulates the chaining value and streams the 8-word digest after the final block.
module sha256_funcs (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] s0_in,
  input  logic [31:0] s1_in,
  output logic [31:0] ch,
  output logic [31:0] maj,
  output logic [31:0] bsig0,
  output logic [31:0] bsig1,
  output logic [31:0] ssig0,
  output logic [31:0] ssig1
);
  assign ch    = (e & f) ^ (~e & g);
  assign maj   = (a & b) ^ (a & c) ^ (b & c);
  assign bsig0 = {a[1:0], a[31:2]} ^ {a[12:0], a[31:13]} ^ {a[21:0], a[31:22]};
  assign bsig1 = {e[5:0], e[31:6]} ^ {e[10:0], e[31:11]} ^ {e[24:0], e[31:25]};
  assign ssig0 = {s0_in[6:0], s0_in[31:7]} ^ {s0_in[17:0], s0_in[31:18]} ^ {3'b0, s0_in[31:3]};
  assign ssig1 = {s1_in[16:0], s1_in[31:17]} ^ {s1_in[18:0], s1_in[31:19]} ^ {10'b0, s1_in[31:10]};
endmodule

module sha256_compress_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic        w_valid,
  input  logic [31:0] w_data,
  input  logic        w_last,
  output logic        w_ready,
  output logic        busy,
  output logic        dout_valid,
  output logic [31:0] dout,
  input  logic        dout_ready
);
  typedef enum logic [1:0] {LOAD, ROUND, UPDATE, OUT} state_t;

  localparam logic [31:0] iv [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  localparam logic [31:0] k_rom [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  state_t      state, state_nxt;
  logic [31:0] hreg [8];
  logic [31:0] v [8];
  logic [31:0] w [16];
  logic [3:0]  wcnt;
  logic [5:0]  t;
  logic [2:0]  k;
  logic        last_r;
  logic        do_init;
  logic        out_fire;
  logic [31:0] ch, maj, bsig0, bsig1, ssig0, ssig1;
  logic [31:0] wt, t1, t2;

  sha256_funcs u_funcs (
    .a(v[0]), .b(v[1]), .c(v[2]), .e(v[4]), .f(v[5]), .g(v[6]),
    .s0_in(w[1]), .s1_in(w[14]),
    .ch(ch), .maj(maj), .bsig0(bsig0), .bsig1(bsig1), .ssig0(ssig0), .ssig1(ssig1)
  );

  // The window always holds W[t-16..t-1]; rounds 0..15 rotate the loaded words back in.
  assign wt       = (t < 6'd16) ? w[0] : (ssig1 + w[9] + ssig0 + w[0]);
  assign t1       = v[7] + bsig1 + ch + k_rom[t] + wt;
  assign t2       = bsig0 + maj;
  assign do_init  = init && (state == LOAD) && (wcnt == 4'd0);
  assign out_fire = dout_valid && dout_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (w_valid && wcnt == 4'd15) state_nxt = ROUND;
      ROUND:   if (t == 6'd63) state_nxt = UPDATE;
      UPDATE:  state_nxt = last_r ? OUT : LOAD;
      OUT:     if (out_fire && k == 3'd7) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    w_ready = (state == LOAD);
    busy    = (state == ROUND) || (state == UPDATE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        hreg[i] <= iv[i];
        v[i]    <= '0;
      end
      for (int i = 0; i < 16; i++) w[i] <= '0;
      wcnt       <= '0;
      t          <= '0;
      k          <= '0;
      last_r     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (do_init)
            for (int i = 0; i < 8; i++) hreg[i] <= iv[i];
          if (w_valid) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_data;
            wcnt  <= wcnt + 4'd1;
            if (wcnt == 4'd15) begin
              last_r <= w_last;
              t      <= '0;
              for (int i = 0; i < 8; i++) v[i] <= hreg[i];
            end
          end
        end
        ROUND: begin
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= wt;
          v[7]  <= v[6];
          v[6]  <= v[5];
          v[5]  <= v[4];
          v[4]  <= v[3] + t1;
          v[3]  <= v[2];
          v[2]  <= v[1];
          v[1]  <= v[0];
          v[0]  <= t1 + t2;
          t     <= (t == 6'd63) ? 6'd0 : t + 6'd1;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hreg[i] <= hreg[i] + v[i];
          k <= '0;
        end
        OUT: begin
          // First OUT cycle only registers H0; afterwards each handshake presents the next word.
          if (!dout_valid) begin
            dout_valid <= 1'b1;
            dout       <= hreg[k];
          end else if (dout_ready) begin
            if (k == 3'd7) begin
              dout_valid <= 1'b0;
              k          <= '0;
              for (int i = 0; i < 8; i++) hreg[i] <= iv[i];
            end else begin
              k    <= k + 3'd1;
              dout <= hreg[k + 3'd1];
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule
